l2_cache_control_nway: RTL

L2_CACHE_CONTROL_NWAY -- requirements
Module: l2_cache_control_nway

---
 rtl/l2_cache_control_nway_pkg.sv | 69 ++++++
 rtl/l2_cache_control_nway_plru_tree.sv | 19 +
 rtl/l2_cache_control_nway.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/l2_cache_control_nway_pkg.sv
// Shared cache mux types for the L2 controller: datapath select enums,
// controller states and the tree pseudo-LRU victim/update helpers.
package l2_cache_control_nway_pkg;

    typedef enum logic {
        CPU_DATA = 1'b0,
        MEM_DATA = 1'b1
    } data_src_t;

    typedef enum logic {
        MISS_ADDR   = 1'b0,
        VICTIM_ADDR = 1'b1
    } pmem_addr_sel_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WRITEBACK = 3'd2,
        FILL      = 3'd3,
        INSTALL   = 3'd4
    } cache_state_t;

    // Widest supported tree: 8 ways -> 7 tree bits, 3-bit way index.
    localparam int PLRU_MAX_W = 7;
    localparam int WAY_MAX_W  = 3;

    // Walk from the root: a 0 bit sends us to the lower-index child
    // (2i+1), a 1 bit to the upper one (2i+2). Leaves sit at heap
    // positions num_ways-1 .. 2*num_ways-2.
    function automatic logic [WAY_MAX_W-1:0] plru_victim(
        input logic [PLRU_MAX_W-1:0] tree,
        input logic [3:0]            num_ways
    );
        logic [3:0] node;
        logic [3:0] leaf;
        node = 4'd0;
        for (int lvl = 0; lvl < WAY_MAX_W; lvl++) begin
            if (node < (num_ways - 4'd1)) begin
                node = (node << 1) + (tree[node[2:0]] ? 4'd2 : 4'd1);
            end
        end
        leaf = node - (num_ways - 4'd1);
        return leaf[WAY_MAX_W-1:0];
    endfunction

    // Climb from the accessed leaf to the root, pointing every parent on
    // the path at the sibling subtree. Left children have odd heap
    // positions, so the new bit is simply the child's LSB.
    function automatic logic [PLRU_MAX_W-1:0] plru_update(
        input logic [PLRU_MAX_W-1:0] tree,
        input logic [WAY_MAX_W-1:0]  way,
        input logic [3:0]            num_ways
    );
        logic [PLRU_MAX_W-1:0] result;
        logic [3:0]            node;
        logic [3:0]            parent;
        result = tree;
        node   = {1'b0, way} + num_ways - 4'd1;
        for (int lvl = 0; lvl < WAY_MAX_W; lvl++) begin
            if (node != 4'd0) begin
                parent              = (node - 4'd1) >> 1;
                result[parent[2:0]] = node[0];
                node                = parent;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/l2_cache_control_nway_plru_tree.sv
// Combinational tree pseudo-LRU: picks the replacement way for a set and
// produces the updated tree bits after an access to a given way.
module plru_tree
    import l2_cache_control_nway_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    localparam int WAY_IDX_W = $clog2(NUM_WAYS),
    localparam int PLRU_W = NUM_WAYS - 1
) (
    input  logic [PLRU_W-1:0]    i_tree,
    input  logic [WAY_IDX_W-1:0] i_accessWay,
    output logic [WAY_IDX_W-1:0] o_victim,
    output logic [PLRU_W-1:0]    o_tree
);

    assign o_victim = WAY_IDX_W'(plru_victim(7'(i_tree), 4'(NUM_WAYS)));
    assign o_tree   = PLRU_W'(plru_update(7'(i_tree), 3'(i_accessWay), 4'(NUM_WAYS)));

endmodule

// File: rtl/l2_cache_control_nway.sv
// N-way L2 cache controller: hit lookup, dirty victim writeback, line fill
// and install, with tree pseudo-LRU replacement.
module l2_cache_control_nway
    import l2_cache_control_nway_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    localparam int WAY_IDX_W = $clog2(NUM_WAYS),
    localparam int PLRU_W = NUM_WAYS - 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    input  logic                 pmem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic [NUM_WAYS-1:0]  way_hit,
    input  logic [NUM_WAYS-1:0]  valid,
    input  logic [NUM_WAYS-1:0]  dirty,
    input  logic [PLRU_W-1:0]    plru_dataout,
    output logic [NUM_WAYS-1:0]  valid_load,
    output logic [NUM_WAYS-1:0]  dirty_load,
    output logic [NUM_WAYS-1:0]  tag_load,
    output logic                 valid_datain,
    output logic                 dirty_datain,
    output logic                 plru_load,
    output logic [PLRU_W-1:0]    plru_datain,
    output logic                 mbr_load,
    output logic [NUM_WAYS-1:0]  data_we,
    output data_src_t            data_src_sel,
    output logic [WAY_IDX_W-1:0] dataout_way,
    output pmem_addr_sel_t       pmem_addr_sel
);

    cache_state_t          r_state;
    cache_state_t          w_nextState;
    logic [WAY_IDX_W-1:0]  r_victim;
    logic [WAY_IDX_W-1:0]  w_hitWay;
    logic [WAY_IDX_W-1:0]  w_invalidWay;
    logic [WAY_IDX_W-1:0]  w_plruVictim;
    logic [WAY_IDX_W-1:0]  w_missVictim;
    logic [PLRU_W-1:0]     w_plruUpdated;
    logic [NUM_WAYS-1:0]   w_hitOneHot;
    logic [NUM_WAYS-1:0]   w_victimOneHot;
    logic                  w_anyHit;
    logic                  w_anyInvalid;
    logic                  w_request;
    logic                  w_isWrite;
    logic                  w_missCapture;

    plru_tree #(
        .NUM_WAYS(NUM_WAYS)
    ) u_plruTree (
        .i_tree      (plru_dataout),
        .i_accessWay (w_hitWay),
        .o_victim    (w_plruVictim),
        .o_tree      (w_plruUpdated)
    );

    assign w_anyHit       = |way_hit;
    assign w_anyInvalid   = ~&valid;
    assign w_request      = mem_read | mem_write;
    assign w_isWrite      = mem_write & ~mem_read;
    assign w_missVictim   = w_anyInvalid ? w_invalidWay : w_plruVictim;
    assign w_hitOneHot    = NUM_WAYS'(1) << w_hitWay;
    assign w_victimOneHot = NUM_WAYS'(1) << r_victim;
    assign w_missCapture  = (r_state == LOOKUP) && w_request && !w_anyHit;

    // Lowest-index hit way and lowest-index invalid way (priority encoders).
    always_comb begin
        w_hitWay     = '0;
        w_invalidWay = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (way_hit[i]) w_hitWay = WAY_IDX_W'(i);
            if (!valid[i])  w_invalidWay = WAY_IDX_W'(i);
        end
    end

    // State register; synchronous reset returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    // Victim is captured only on a miss so it holds through WRITEBACK..INSTALL.
    always_ff @(posedge clk) begin
        if (rst)                r_victim <= '0;
        else if (w_missCapture) r_victim <= w_missVictim;
    end

    // Next-state and control outputs; every output defaults to idle values.
    always_comb begin
        w_nextState   = r_state;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        valid_load    = '0;
        dirty_load    = '0;
        tag_load      = '0;
        valid_datain  = 1'b0;
        dirty_datain  = 1'b0;
        plru_load     = 1'b0;
        plru_datain   = '0;
        mbr_load      = 1'b0;
        data_we       = '0;
        data_src_sel  = CPU_DATA;
        dataout_way   = '0;
        pmem_addr_sel = MISS_ADDR;

        case (r_state)
            IDLE: begin
                if (w_request) w_nextState = LOOKUP;
            end

            LOOKUP: begin
                if (!w_request) begin
                    w_nextState = IDLE;
                end else if (w_anyHit) begin
                    mem_resp    = 1'b1;
                    plru_load   = 1'b1;
                    plru_datain = w_plruUpdated;
                    dataout_way = w_hitWay;
                    if (w_isWrite) begin
                        data_we      = w_hitOneHot;
                        dirty_load   = w_hitOneHot;
                        dirty_datain = 1'b1;
                    end
                    w_nextState = IDLE;
                end else if (valid[w_missVictim] && dirty[w_missVictim]) begin
                    w_nextState = WRITEBACK;
                end else begin
                    w_nextState = FILL;
                end
            end

            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = VICTIM_ADDR;
                dataout_way   = r_victim;
                if (pmem_resp) begin
                    dirty_load   = w_victimOneHot;
                    dirty_datain = 1'b0;
                    w_nextState  = FILL;
                end
            end

            FILL: begin
                pmem_read     = 1'b1;
                mbr_load      = 1'b1;
                pmem_addr_sel = MISS_ADDR;
                if (pmem_resp) w_nextState = INSTALL;
            end

            INSTALL: begin
                tag_load     = w_victimOneHot;
                valid_load   = w_victimOneHot;
                valid_datain = 1'b1;
                dirty_load   = w_victimOneHot;
                dirty_datain = 1'b0;
                data_we      = w_victimOneHot;
                data_src_sel = MEM_DATA;
                w_nextState  = LOOKUP;
            end

            default: w_nextState = IDLE;
        endcase
    end

endmodule
